// File: rtl/game_pkg.sv
// Shared definitions for the player sequencing logic: phase encoding,
// direction bit positions and screen geometry.
package game_pkg;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_PLAY      = 3'd1,
    PH_DYING     = 3'd2,
    PH_RESPAWN   = 3'd3,
    PH_GAME_OVER = 3'd4
  } phase_t;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Wide enough for the longest countdown (death freeze).
  localparam int TIMER_W = 7;

  function automatic logic [3:0] pick_dir(input logic [3:0] b);
    logic [3:0] d;
    d = '0;
    if (b[DIR_UP])         d[DIR_UP]    = 1'b1;
    else if (b[DIR_DOWN])  d[DIR_DOWN]  = 1'b1;
    else if (b[DIR_LEFT])  d[DIR_LEFT]  = 1'b1;
    else if (b[DIR_RIGHT]) d[DIR_RIGHT] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/move_repeat_timer.sv
// Tick down-counter shared by move auto-repeat and the death freeze.
// Expires on the tick that takes it to terminal count, then reloads itself.
module move_repeat_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               restart,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expire
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (restart) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= (count == TIMER_W'(1)) ? load_val : count - TIMER_W'(1);
    end
  end

  assign expire = tick && (count == TIMER_W'(1));

endmodule

// File: rtl/player_flow_controller.sv
// Game-phase sequencer for the player: lives, score, respawn reset and
// rate-limited, bounds-checked move strobes.
//   state        | meaning
//   PH_IDLE      | power-up, waiting for any button press
//   PH_PLAY      | player live, moves/goal/death evaluated each cycle
//   PH_DYING     | frozen for DEATH_TICKS frame ticks
//   PH_RESPAWN   | single cycle holding the player at its start position
//   PH_GAME_OVER | no lives left, waiting for any button press
module player_flow_controller
  import game_pkg::*;
#(
  parameter int MOVE_TICKS  = 8,
  parameter int DEATH_TICKS = 60,
  parameter int LIVES       = 3,
  parameter int STEP        = 12,
  parameter int H_MAX       = SCREEN_W - STEP,
  parameter int V_MAX       = SCREEN_H - STEP,
  parameter int GOAL_V      = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  btns,
  input  logic [11:0] hPos,
  input  logic [11:0] vPos,
  input  logic        player_dead,
  output logic        upEnable,
  output logic        downEnable,
  output logic        leftEnable,
  output logic        rightEnable,
  output logic        move_strobe,
  output logic [3:0]  move_dir,
  output logic        player_rst_n,
  output logic [2:0]  lives,
  output logic [7:0]  score,
  output logic [2:0]  phase
);

  phase_t state, state_nx;
  logic [3:0] btns_q, sel_q;
  logic [3:0] rise, sel;
  logic       sel_rise, dir_change, goal, expire;
  logic [12:0] h13, v13;
  logic [3:0] legal;

  logic [2:0] lives_nx;
  logic [7:0] score_nx;
  logic       strobe_nx;
  logic [3:0] dir_nx, en_nx;
  logic       restart;
  logic [TIMER_W-1:0] load_val;

  assign rise       = btns & ~btns_q;
  assign sel        = pick_dir(btns);
  assign sel_rise   = |(sel & rise);
  assign dir_change = (sel != sel_q);
  assign goal       = vPos < 12'(GOAL_V);

  // 13-bit compares so pos + STEP cannot wrap.
  assign h13 = {1'b0, hPos};
  assign v13 = {1'b0, vPos};
  assign legal[DIR_UP]    = v13 >= 13'(STEP);
  assign legal[DIR_DOWN]  = (v13 + 13'(STEP)) <= 13'(V_MAX);
  assign legal[DIR_LEFT]  = h13 >= 13'(STEP);
  assign legal[DIR_RIGHT] = (h13 + 13'(STEP)) <= 13'(H_MAX);

  move_repeat_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .restart  (restart),
    .load_val (load_val),
    .expire   (expire)
  );

  always_comb begin
    state_nx  = state;
    lives_nx  = lives;
    score_nx  = score;
    strobe_nx = 1'b0;
    dir_nx    = '0;
    en_nx     = '0;
    restart   = 1'b1;
    load_val  = TIMER_W'(MOVE_TICKS);
    case (state)
      PH_IDLE, PH_GAME_OVER: begin
        if (|rise) begin
          state_nx = PH_RESPAWN;
          lives_nx = 3'(LIVES);
          score_nx = '0;
        end
      end
      PH_RESPAWN: state_nx = PH_PLAY;
      PH_DYING: begin
        restart = 1'b0;
        if (expire) state_nx = PH_RESPAWN;
      end
      PH_PLAY: begin
        en_nx   = legal;
        restart = sel_rise || dir_change;
        if (player_dead) begin
          restart  = 1'b1;
          load_val = TIMER_W'(DEATH_TICKS);
          if (lives == 3'd1) begin
            state_nx = PH_GAME_OVER;
            lives_nx = '0;
          end else begin
            state_nx = PH_DYING;
            lives_nx = lives - 3'd1;
          end
        end else if (goal) begin
          if (score != 8'hFF) score_nx = score + 8'd1;
          state_nx = PH_RESPAWN;
        end else if ((sel_rise || (expire && !restart && |sel)) && |(sel & legal)) begin
          // Blocked moves vanish, but the repeat timer keeps its cadence.
          strobe_nx = 1'b1;
          dir_nx    = sel;
        end
      end
      default: state_nx = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= PH_IDLE;
      btns_q       <= '0;
      sel_q        <= '0;
      lives        <= 3'(LIVES);
      score        <= '0;
      player_rst_n <= 1'b0;
      move_strobe  <= 1'b0;
      move_dir     <= '0;
      upEnable     <= 1'b0;
      downEnable   <= 1'b0;
      leftEnable   <= 1'b0;
      rightEnable  <= 1'b0;
    end else begin
      state        <= state_nx;
      btns_q       <= btns;
      sel_q        <= sel;
      lives        <= lives_nx;
      score        <= score_nx;
      player_rst_n <= (state_nx == PH_PLAY) || (state_nx == PH_DYING);
      move_strobe  <= strobe_nx;
      move_dir     <= dir_nx;
      upEnable     <= en_nx[DIR_UP];
      downEnable   <= en_nx[DIR_DOWN];
      leftEnable   <= en_nx[DIR_LEFT];
      rightEnable  <= en_nx[DIR_RIGHT];
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_player_flow_controller.sv
// Directed bench for player_flow_controller: a vector table for single-cycle
// behaviour plus sequences for repeat timing, death freeze and saturation.
module tb_player_flow_controller;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  btns = '0;
  logic [11:0] hPos = 12'd320;
  logic [11:0] vPos = 12'd300;
  logic        player_dead = 1'b0;
  logic        upEnable, downEnable, leftEnable, rightEnable;
  logic        move_strobe, player_rst_n;
  logic [3:0]  move_dir;
  logic [2:0]  lives, phase;
  logic [7:0]  score;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  player_flow_controller dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .btns         (btns),
    .hPos         (hPos),
    .vPos         (vPos),
    .player_dead  (player_dead),
    .upEnable     (upEnable),
    .downEnable   (downEnable),
    .leftEnable   (leftEnable),
    .rightEnable  (rightEnable),
    .move_strobe  (move_strobe),
    .move_dir     (move_dir),
    .player_rst_n (player_rst_n),
    .lives        (lives),
    .score        (score),
    .phase        (phase)
  );

  typedef struct {
    logic        r;
    logic [3:0]  b;
    logic [11:0] h;
    logic [11:0] v;
    logic        d;
    logic        t;
    logic [2:0]  ph;
    logic        st;
    logic [3:0]  dir;
    logic [3:0]  en;
    logic [2:0]  lv;
    logic [7:0]  sc;
    logic        rn;
  } vec_t;

  vec_t tv[22];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [3:0] b, input logic tk, input logic dd);
    btns = b;
    tick = tk;
    player_dead = dd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] en_vec();
    return {rightEnable, leftEnable, downEnable, upEnable};
  endfunction

  task automatic die_wait(input logic [2:0] lv_exp);
    for (int k = 1; k <= 60; k++) begin
      cyc((k == 30) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      chk("dying_phase", 16'(phase), (k == 60) ? 16'(PH_RESPAWN) : 16'(PH_DYING));
      if (k == 30) chk("dying_no_strobe", 16'(move_strobe), 16'd0);
      if (k < 60) cyc(4'b0000, 1'b0, 1'b0);
    end
    cyc(4'b0000, 1'b0, 1'b0);
    chk("respawn_play", 16'(phase), 16'(PH_PLAY));
    chk("respawn_lives", 16'(lives), 16'(lv_exp));
    chk("respawn_rst_n", 16'(player_rst_n), 16'd1);
  endtask

  initial begin
    //        r  btns     h       v       d  t  phase        st dir      en       lv  sc  rn
    tv[0]  = '{0, 4'b0000, 12'd320, 12'd300, 0, 0, PH_IDLE,     0, 4'b0000, 4'b0000, 3, 0, 0};
    tv[1]  = '{1, 4'b0000, 12'd320, 12'd300, 0, 0, PH_IDLE,     0, 4'b0000, 4'b0000, 3, 0, 0};
    tv[2]  = '{1, 4'b0001, 12'd320, 12'd300, 0, 0, PH_RESPAWN,  0, 4'b0000, 4'b0000, 3, 0, 0};
    tv[3]  = '{1, 4'b0000, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b0000, 3, 0, 1};
    tv[4]  = '{1, 4'b0000, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1111, 3, 0, 1};
    tv[5]  = '{1, 4'b0100, 12'd320, 12'd300, 0, 0, PH_PLAY,     1, 4'b0100, 4'b1111, 3, 0, 1};
    tv[6]  = '{1, 4'b0100, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1111, 3, 0, 1};
    tv[7]  = '{1, 4'b0000, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1111, 3, 0, 1};
    tv[8]  = '{1, 4'b1001, 12'd320, 12'd300, 0, 0, PH_PLAY,     1, 4'b0001, 4'b1111, 3, 0, 1};
    tv[9]  = '{1, 4'b0000, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1111, 3, 0, 1};
    tv[10] = '{1, 4'b1000, 12'd628, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b0111, 3, 0, 1};
    tv[11] = '{1, 4'b0000, 12'd628, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b0111, 3, 0, 1};
    tv[12] = '{1, 4'b0000, 12'd0,   12'd468, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1001, 3, 0, 1};
    tv[13] = '{1, 4'b0010, 12'd0,   12'd468, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1001, 3, 0, 1};
    tv[14] = '{1, 4'b0100, 12'd320, 12'd300, 0, 1, PH_PLAY,     1, 4'b0100, 4'b1111, 3, 0, 1};
    tv[15] = '{1, 4'b0100, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1111, 3, 0, 1};
    tv[16] = '{1, 4'b0000, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1111, 3, 0, 1};
    tv[17] = '{1, 4'b0001, 12'd320, 12'd0,   0, 0, PH_RESPAWN,  0, 4'b0000, 4'b1110, 3, 1, 0};
    tv[18] = '{1, 4'b0001, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b0000, 3, 1, 1};
    tv[19] = '{1, 4'b0000, 12'd320, 12'd300, 0, 0, PH_PLAY,     0, 4'b0000, 4'b1111, 3, 1, 1};
    tv[20] = '{1, 4'b0100, 12'd320, 12'd5,   1, 0, PH_DYING,    0, 4'b0000, 4'b1110, 2, 1, 1};
    tv[21] = '{1, 4'b0000, 12'd320, 12'd300, 0, 0, PH_DYING,    0, 4'b0000, 4'b0000, 2, 1, 1};

    for (int i = 0; i < 22; i++) begin
      rst  = tv[i].r;
      hPos = tv[i].h;
      vPos = tv[i].v;
      cyc(tv[i].b, tv[i].t, tv[i].d);
      chk($sformatf("v%0d_phase", i), 16'(phase), 16'(tv[i].ph));
      chk($sformatf("v%0d_strobe", i), 16'(move_strobe), 16'(tv[i].st));
      chk($sformatf("v%0d_dir", i), 16'(move_dir), 16'(tv[i].dir));
      chk($sformatf("v%0d_en", i), 16'(en_vec()), 16'(tv[i].en));
      chk($sformatf("v%0d_lives", i), 16'(lives), 16'(tv[i].lv));
      chk($sformatf("v%0d_score", i), 16'(score), 16'(tv[i].sc));
      chk($sformatf("v%0d_rst_n", i), 16'(player_rst_n), 16'(tv[i].rn));
    end

    // First death freeze: 60 ticks, buttons ignored.
    die_wait(3'd2);

    // Held left: edge strobe, then repeats on ticks 8 and 16.
    hPos = 12'd320;
    vPos = 12'd300;
    cyc(4'b0100, 1'b0, 1'b0);
    chk("hold_first_strobe", 16'(move_strobe), 16'd1);
    chk("hold_first_dir", 16'(move_dir), 16'b0100);
    for (int k = 1; k <= 20; k++) begin
      cyc(4'b0100, 1'b1, 1'b0);
      chk("hold_tick_strobe", 16'(move_strobe), (k % 8 == 0) ? 16'd1 : 16'd0);
      if (k % 8 == 0) chk("hold_tick_dir", 16'(move_dir), 16'b0100);
      cyc(4'b0100, 1'b0, 1'b0);
      chk("hold_gap_strobe", 16'(move_strobe), 16'd0);
    end
    cyc(4'b0000, 1'b0, 1'b0);

    // Held down at the bottom edge: dropped moves keep the repeat cadence.
    vPos = 12'd468;
    cyc(4'b0010, 1'b0, 1'b0);
    chk("blocked_edge_strobe", 16'(move_strobe), 16'd0);
    chk("blocked_down_en", 16'(downEnable), 16'd0);
    for (int k = 1; k <= 16; k++) begin
      vPos = (k <= 10) ? 12'd468 : 12'd300;
      cyc(4'b0010, 1'b1, 1'b0);
      chk("blocked_tick_strobe", 16'(move_strobe), (k == 16) ? 16'd1 : 16'd0);
      cyc(4'b0010, 1'b0, 1'b0);
    end
    cyc(4'b0000, 1'b0, 1'b0);

    // Second and third deaths.
    cyc(4'b0000, 1'b0, 1'b1);
    chk("death2_phase", 16'(phase), 16'(PH_DYING));
    chk("death2_lives", 16'(lives), 16'd1);
    die_wait(3'd1);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("death3_phase", 16'(phase), 16'(PH_GAME_OVER));
    chk("death3_lives", 16'(lives), 16'd0);
    chk("death3_rst_n", 16'(player_rst_n), 16'd0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("gameover_hold", 16'(phase), 16'(PH_GAME_OVER));
    chk("gameover_en", 16'(en_vec()), 16'd0);

    // Restart, then park in the goal row until the score saturates.
    cyc(4'b0001, 1'b0, 1'b0);
    chk("restart_phase", 16'(phase), 16'(PH_RESPAWN));
    chk("restart_lives", 16'(lives), 16'd3);
    chk("restart_score", 16'(score), 16'd0);
    vPos = 12'd5;
    repeat (600) cyc(4'b0000, 1'b0, 1'b0);
    chk("score_saturate", 16'(score), 16'd255);
    chk("score_lives", 16'(lives), 16'd3);

    // Reset arriving mid-freeze.
    vPos = 12'd300;
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("pre_rst_phase", 16'(phase), 16'(PH_PLAY));
    chk("pre_rst_score", 16'(score), 16'd255);
    cyc(4'b0000, 1'b0, 1'b1);
    chk("pre_rst_dying", 16'(phase), 16'(PH_DYING));
    chk("pre_rst_lives", 16'(lives), 16'd2);
    repeat (3) cyc(4'b0000, 1'b1, 1'b0);
    rst = 1'b0;
    cyc(4'b0001, 1'b1, 1'b0);
    chk("rst_phase", 16'(phase), 16'(PH_IDLE));
    chk("rst_lives", 16'(lives), 16'd3);
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_rst_n", 16'(player_rst_n), 16'd0);
    chk("rst_strobe", 16'(move_strobe), 16'd0);
    chk("rst_dir", 16'(move_dir), 16'd0);
    chk("rst_en", 16'(en_vec()), 16'd0);
    rst = 1'b1;
    cyc(4'b0000, 1'b0, 1'b0);
    chk("post_rst_idle", 16'(phase), 16'(PH_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/player_flow_controller.md
# player_flow_controller

Sequencing controller for the player object in the VGA game. It turns raw button levels into rate-limited, bounds-checked move strobes and per-direction enables for the player rectangle. It tracks lives and score, and drives the respawn reset and game-phase state seen by the rest of the display pipeline. It sits between the button synchroniser and the player object, clocked from the system pixel/logic clock.

## Interface
- `MOVE_TICKS`, 8: frame ticks between auto-repeat moves while a button is held.
- `DEATH_TICKS`, 60: frame ticks the player stays frozen after death.
- `LIVES`, 3: lives loaded at game start (1..7).
- `STEP`, 12: pixels per move; equals the player square size.
- `H_MAX`, 628: largest legal `hPos`, which is 640−STEP.
- `V_MAX`, 468: largest legal `vPos`, which is 480−STEP.
- `GOAL_V`, 12: `vPos` < GOAL_V counts as reaching the goal row.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `tick`  in  1  one-cycle frame pulse (≈60 Hz).
- `btns`  in  4  synchronised button levels: [0]=up, [1]=down, [2]=left, [3]=right.
- `hPos`, `vPos`  in  12 each  current player position.
- `player_dead`  in  1  collision flag from the player object.
- `upEnable`, `downEnable`, `leftEnable`, `rightEnable`  out  1 each  direction legal this cycle.
- `move_strobe`  out  1  one-cycle move request to the player object.
- `move_dir`  out  4  one-hot direction, valid with `move_strobe`.
- `player_rst_n`  out  1  active-low reset to the player object; low means the player sits at its start position.
- `lives`  out  3  remaining lives.
- `score`  out  8  goals reached, saturating at 255.
- `phase`  out  3  encoded FSM state.

## Operation
- FSM states: IDLE, PLAY, DYING, RESPAWN, GAME_OVER.
- IDLE / GAME_OVER:
  - Any rising edge on `btns` → RESPAWN.
  - On that transition, `lives`=LIVES and `score`=0.
- PLAY:
  - Priority per cycle: `player_dead` > goal > move.
  - `player_dead`=1: if `lives`==1 → GAME_OVER with `lives`=0; else `lives`−1 and go to DYING.
  - Goal (`vPos` < GOAL_V): `score`+1 (saturating) and go to RESPAWN.
- DYING: count DEATH_TICKS `tick` pulses, then go to RESPAWN. `btns` are ignored.
- RESPAWN: lasts exactly one cycle with `player_rst_n`=0, then go to PLAY.
- `player_rst_n`: 0 in IDLE, GAME_OVER and RESPAWN; 1 in PLAY and DYING.
- Enables, PLAY only (all 0 in other states):
  - `upEnable` = `vPos` ≥ STEP.
  - `downEnable` = `vPos` + STEP ≤ V_MAX.
  - `leftEnable` = `hPos` ≥ STEP.
  - `rightEnable` = `hPos` + STEP ≤ H_MAX.
  - Compare in 13 bits so there is no wrap-around.
- Move selection:
  - The selected direction is the highest-priority pressed button: up > down > left > right.
  - A move fires on a rising edge of the selected button.
  - A move also fires while the button is held, once every MOVE_TICKS `tick`s after the previous move.
  - The repeat counter restarts on each rising edge and on every direction change.
- A move whose direction enable is 0 is dropped silently.
- The repeat counter keeps running when a move is dropped.

## Timing
- All outputs are registered.
- Reset values:
  - `phase`=IDLE, `lives`=LIVES, `score`=0, `player_rst_n`=0.
  - `move_strobe`=0, `move_dir`=0, all enables 0.
- Edge detection uses a 1-cycle `btns` delay register.
- `move_strobe` rises 1 cycle after the `btns` edge, or 1 cycle after the qualifying `tick`, and is high for exactly 1 cycle.
- `move_dir` is 0 whenever `move_strobe`=0.
- `player_dead` is sampled only in PLAY. The state change is visible 1 cycle later, and `move_strobe` is suppressed in that same cycle.
- DYING length: the transition happens on the cycle after the DEATH_TICKS-th `tick`.
- `rst` low in any state returns to the reset values on the next edge, including when it arrives mid-DYING.
- `tick` and a button edge in the same cycle produce a single strobe.

## Structure
- Shared `game_pkg` holds:
  - the phase encoding (IDLE=0, PLAY=1, DYING=2, RESPAWN=3, GAME_OVER=4);
  - the direction bit indices;
  - the screen constants 640 and 480.
- Sub-module `move_repeat_timer` holds the tick counter with restart and expire outputs.
- The same `move_repeat_timer` instance also serves the DYING countdown; it is reloaded with DEATH_TICKS.

## Test plan
- Reset, release, pulse `btns`=0001 → RESPAWN for 1 cycle (`player_rst_n`=0), then PLAY, with `lives`=3 and `score`=0.
- PLAY at `hPos`=320, `vPos`=300; hold `btns`=0100 for 20 ticks → first strobe 1 cycle after the edge, then strobes at ticks 8 and 16, with `move_dir`=0100.
- `vPos`=0, press up → `upEnable`=0 and no strobe. `hPos`=628 → `rightEnable`=0.
- Press up and right together → `move_dir`=0001 only.
- `player_dead` pulsed three times, each followed by 60 ticks → `lives` 2, 1, then GAME_OVER with `lives`=0. `player_dead` coincident with `vPos`=5 → death taken and `score` unchanged.
- `score` preset to 255, reach goal → `score` stays 255. `rst` asserted mid-DYING → IDLE with reset values on the next edge.
